fdiv_iter: RTL and testbench
============================

// Module: fdiv_iter
// PURPOSE
//  Iterative single-precision FP divider y = x1 / x2, the inverse operation of the pipelined fmul.
//  Uses radix-2 restoring division, one quotient bit per cycle, with a valid/ready handshake on both sides.
//  Sits beside fmul in the FPU execute stage. Number handling matches fmul:
//  exponent==0 operands are zero (denormals flushed), and exponent 255 is not special-cased.
// PARAMETERS
//  FAST_SPECIAL  1  1: zero-operand cases skip DIV and finish early; 0: all ops take full latency
// PORTS
//  clk        in   1   clock; all state changes on rising edge
//  rstn       in   1   asynchronous active-low reset
//  x1         in   32  dividend (IEEE-754 single), sampled on accept
//  x2         in   32  divisor, sampled on accept
//  valid_in   in   1   operands valid
//  ready_out  out  1   divider idle; accept = valid_in & ready_out at a rising edge
//  y          out  32  quotient, stable while valid_out=1
//  valid_out  out  1   result valid; held until consumed
//  ready_in   in   1   consumer ready; consume = valid_out & ready_in at a rising edge
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE, y=0, valid_out=0, ready_out=1, internal regs cleared.
//   Reset mid-operation aborts the op; no result is produced.
//  FSM: IDLE -> PREP -> DIV(25 cycles) -> ROUND -> DONE -> IDLE.
//   IDLE: ready_out=1. On accept, latch operands and go to PREP.
//   PREP: sy = s1^s2, ma = {1,m1}, mb = {1,m2}.
//    If ma<mb: dividend = ma<<1, adj=1; else dividend = ma, adj=0.
//    eb = e1 - e2 + 127 - adj, held as signed 10-bit.
//    If e2==0 or e1==0 and FAST_SPECIAL=1: go straight to ROUND.
//   DIV: 25 iterations, each yielding one quotient bit q[24:0] in [1,2) (q[24]=1).
//    Per iteration: if rem >= mb, subtract mb and q bit=1; then rem <<= 1. 5-bit counter 24..0.
//   ROUND: guard=q[0], sticky=|rem, mant=q[23:1].
//    Round to nearest even: add 1 if guard & (sticky | mant[0]).
//    Carry out of mant: mant=0, eb+=1.
//    Resolve in this priority order:
//     e2==0 -> y={sy,8'hFF,23'h0} (covers 0/0 too)
//     e1==0 -> y={sy,31'h0}
//     eb>=255 -> {sy,8'hFF,23'h0}
//     eb<=0 -> {sy,31'h0}
//     else {sy,eb[7:0],mant}.
//    y is registered here; valid_out=1 from the next cycle.
//   DONE: valid_out=1, y held. On consume go to IDLE (valid_out=0).
//    ready_out=0 in DONE, so a valid_in in the consume cycle is accepted one cycle later, in IDLE.
//  Latency: valid_out rises at the 28th rising edge after the accept edge.
//   FAST_SPECIAL zero cases: 3rd rising edge.
//   Throughput: one op per 29 cycles when ready_in is held at 1.
//  ready_out is a pure decode of state==IDLE, so it is glitch-free and reads 1 during reset.
//  x1/x2 may change freely when not being accepted; latched copies are used.
//  valid_in while busy is ignored and not queued.
//  Remainder width: 26 bits (dividend up to 2*ma < 2^25, plus shift headroom).
// TESTING
//  6.0/2.0: 40C00000/40000000 -> y=40400000, valid_out at edge 28 after accept.
//  1.0/3.0: 3F800000/40400000 -> y=3EAAAAAB (ma<mb path, round-up via sticky).
//  Specials: -1.0/0 (BF800000/00000000) -> FF800000.
//   0/5.0 (00000000/40A00000) -> 00000000 at edge 3 (FAST_SPECIAL=1) or edge 28 (=0).
//  Range: 7F000000/00800000 -> 7F800000 (overflow).
//   00800000/7F000000 -> 00000000 (underflow, eb=-126).
//  Backpressure: hold ready_in=0 for 10 cycles after valid_out.
//   y and valid_out stay stable, ready_out=0 and valid_in is ignored.
//   After consume, IDLE then the next op is accepted.
//  Reset: assert rstn=0 at DIV iteration 10 -> y=0, valid_out=0, ready_out=1 immediately.
//   A fresh 6.0/2.0 after release completes correctly.

Source files
------------

// File: rtl/fdiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : fdiv_iter
//  Brief    : Iterative single-precision divider y = x1 / x2, one quotient
//             bit per cycle (radix-2 restoring), valid/ready on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module fdiv_iter #(
  parameter int FAST_SPECIAL = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [31:0] y,
  output logic        valid_out,
  input  logic        ready_in
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_DIV   = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_x1;
  logic [31:0]       r_x2;
  logic [31:0]       r_y;
  logic [25:0]       r_rem;
  logic [23:0]       r_q;
  logic signed [9:0] r_eb;
  logic [4:0]        r_cnt;

  logic              w_sy;
  logic              w_e1z;
  logic              w_e2z;
  logic [23:0]       w_ma;
  logic [23:0]       w_mb;
  logic              w_adj;
  logic              w_ge;
  logic              w_inc;
  logic [23:0]       w_mant_r;
  logic [22:0]       w_mant_f;
  logic signed [9:0] w_eb_r;
  logic [31:0]       w_y_res;

  assign w_sy  = r_x1[31] ^ r_x2[31];
  assign w_e1z = (r_x1[30:23] == 8'd0);
  assign w_e2z = (r_x2[30:23] == 8'd0);
  assign w_ma  = {1'b1, r_x1[22:0]};
  assign w_mb  = {1'b1, r_x2[22:0]};
  assign w_adj = (w_ma < w_mb);
  assign w_ge  = (r_rem >= {2'b00, w_mb});

  // r_q keeps q[23:0]; the leading quotient bit is always 1 and shifts out.
  assign w_inc    = r_q[0] & ((|r_rem) | r_q[1]);
  assign w_mant_r = {1'b0, r_q[23:1]} + {23'd0, w_inc};
  assign w_mant_f = w_mant_r[23] ? 23'd0 : w_mant_r[22:0];
  assign w_eb_r   = r_eb + $signed({9'd0, w_mant_r[23]});

  always_comb begin
    w_y_res = {w_sy, w_eb_r[7:0], w_mant_f};
    if (w_e2z)                     w_y_res = {w_sy, 8'hFF, 23'd0};
    else if (w_e1z)                w_y_res = {w_sy, 31'd0};
    else if (w_eb_r >= 10'sd255)   w_y_res = {w_sy, 8'hFF, 23'd0};
    else if (w_eb_r <= 10'sd0)     w_y_res = {w_sy, 31'd0};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    ready_out = 1'b0;
    valid_out = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_out = 1'b1;
        if (valid_in) w_next = S_PREP;
      end
      S_PREP: begin
        if ((FAST_SPECIAL != 0) && (w_e1z || w_e2z)) w_next = S_ROUND;
        else                                          w_next = S_DIV;
      end
      S_DIV: begin
        if (r_cnt == 5'd0) w_next = S_ROUND;
      end
      S_ROUND: w_next = S_DONE;
      S_DONE: begin
        valid_out = 1'b1;
        if (ready_in) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x1  <= 32'd0;
      r_x2  <= 32'd0;
      r_y   <= 32'd0;
      r_rem <= 26'd0;
      r_q   <= 24'd0;
      r_eb  <= 10'sd0;
      r_cnt <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_x1 <= x1;
            r_x2 <= x2;
          end
        end
        S_PREP: begin
          r_rem <= w_adj ? {1'b0, w_ma, 1'b0} : {2'b00, w_ma};
          r_eb  <= $signed({2'b00, r_x1[30:23]} - {2'b00, r_x2[30:23]}
                           + 10'd127 - {9'd0, w_adj});
          r_q   <= 24'd0;
          r_cnt <= 5'd24;
        end
        S_DIV: begin
          r_rem <= w_ge ? ((r_rem - {2'b00, w_mb}) << 1) : (r_rem << 1);
          r_q   <= {r_q[22:0], w_ge};
          r_cnt <= r_cnt - 5'd1;
        end
        S_ROUND: r_y <= w_y_res;
        default: ;
      endcase
    end
  end

  assign y = r_y;

endmodule
`default_nettype wire

// File: tb/tb_fdiv_iter.sv
`default_nettype none
// Testbench for fdiv_iter: directed, random (vs. arithmetic reference model),
// backpressure, mid-operation reset, back-to-back and full-latency variant.
module tb_fdiv_iter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] x1, x2;
  logic        valid_in, ready_in;
  logic        ready_out, valid_out;
  logic [31:0] y;
  logic        valid_in0, ready_in0;
  logic        ready_out0, valid_out0;
  logic [31:0] y0;

  int total = 0;
  int bad   = 0;

  fdiv_iter #(.FAST_SPECIAL(1)) dut (
    .clk(clk), .rstn(rstn), .x1(x1), .x2(x2), .valid_in(valid_in),
    .ready_out(ready_out), .y(y), .valid_out(valid_out), .ready_in(ready_in)
  );

  fdiv_iter #(.FAST_SPECIAL(0)) dut0 (
    .clk(clk), .rstn(rstn), .x1(x1), .x2(x2), .valid_in(valid_in0),
    .ready_out(ready_out0), .y(y0), .valid_out(valid_out0), .ready_in(ready_in0)
  );

  always #5 clk = ~clk;

  // Quotient from exact integer division of the significands, then RNE.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ea, eb, e;
    longint ma, mb, num, q, r, sig;
    logic   g, st;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (eb == 0) return {s, 8'hFF, 23'd0};
    if (ea == 0) return {s, 31'd0};
    ma  = longint'({1'b1, a[22:0]});
    mb  = longint'({1'b1, b[22:0]});
    num = ma << 26;
    q   = num / mb;
    r   = num % mb;
    e   = ea - eb + 127;
    if (q >= (longint'(1) << 26)) begin
      sig = q >> 3;
      g   = q[2];
      st  = (q[1:0] != 2'b00) || (r != 0);
    end else begin
      e   = e - 1;
      sig = q >> 2;
      g   = q[1];
      st  = q[0] || (r != 0);
    end
    if (g && (st || sig[0])) sig = sig + 1;
    if (sig >= (longint'(1) << 24)) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], sig[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0:       v[30:23] = 8'd0;
      1:       ;
      default: v[30:23] = 8'($urandom_range(64, 190));
    endcase
    return v;
  endfunction

  // Latency is counted with the accept edge as edge 1.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    int w;
    @(negedge clk);
    x1 = a; x2 = b; valid_in = 1'b1; ready_in = 1'b1;
    w = 0;
    while (!ready_out && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    valid_in = 1'b0; x1 = $urandom; x2 = $urandom;
    lat = 1;
    while (!valid_out && lat < 100) begin @(posedge clk); #1; lat++; end
    res = y;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; valid_in = 1'b0; ready_in = 1'b1; valid_in0 = 1'b0; ready_in0 = 1'b1;
    x1 = 32'd0; x2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    total++; if (y !== 32'd0) begin bad++; $display("FAIL reset_y: got %h want 00000000", y); end
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ta[6] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F000000, 32'h00800000};
    logic [31:0] tb[6] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h40A00000, 32'h00800000, 32'h7F000000};
    logic [31:0] te[6] = '{32'h40400000, 32'h3EAAAAAB, 32'hFF800000, 32'h00000000, 32'h7F800000, 32'h00000000};
    int          tl[6] = '{28, 28, 3, 3, 28, 28};
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], res, lat);
      total++; if (res !== te[i]) begin bad++; $display("FAIL directed_y[%0d]: got %h want %h", i, res, te[i]); end
      total++; if (lat !== tl[i]) begin bad++; $display("FAIL directed_lat[%0d]: got %0d want %0d", i, lat, tl[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp;
    int          lat, elat;
    for (int i = 0; i < 40; i++) begin
      a = rand_fp(); b = rand_fp();
      exp  = ref_div(a, b);
      elat = (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? 3 : 28;
      do_op(a, b, res, lat);
      total++; if (res !== exp) begin bad++; $display("FAIL random_y %h/%h: got %h want %h", a, b, res, exp); end
      total++; if (lat !== elat) begin bad++; $display("FAIL random_lat %h/%h: got %0d want %0d", a, b, lat, elat); end
    end
  endtask

  task automatic test_slow_special();
    logic [31:0] ta[2] = '{32'h00000000, 32'h40C00000};
    logic [31:0] tb[2] = '{32'h40A00000, 32'h40000000};
    logic [31:0] te[2] = '{32'h00000000, 32'h40400000};
    int lat, w;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      x1 = ta[i]; x2 = tb[i]; valid_in0 = 1'b1; ready_in0 = 1'b1;
      w = 0;
      while (!ready_out0 && w < 100) begin @(negedge clk); w++; end
      @(posedge clk); #1;
      valid_in0 = 1'b0;
      lat = 1;
      while (!valid_out0 && lat < 100) begin @(posedge clk); #1; lat++; end
      total++; if (y0 !== te[i]) begin bad++; $display("FAIL slow_y[%0d]: got %h want %h", i, y0, te[i]); end
      total++; if (lat !== 28) begin bad++; $display("FAIL slow_lat[%0d]: got %0d want 28", i, lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int w;
    @(negedge clk);
    x1 = 32'h40C00000; x2 = 32'h40000000; valid_in = 1'b1; ready_in = 1'b0;
    w = 0;
    while (!ready_out && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    valid_in = 1'b0;
    w = 0;
    while (!valid_out && w < 100) begin @(posedge clk); #1; w++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      x1 = 32'h3F800000; x2 = 32'h40400000; valid_in = 1'b1;
      total++; if (y !== 32'h40400000) begin bad++; $display("FAIL bp_y[%0d]: got %h want 40400000", i, y); end
      total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, valid_out); end
      total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, ready_out); end
    end
    ready_in = 1'b1;
    @(posedge clk); #1;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL bp_consume_valid: got %b want 0", valid_out); end
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL bp_idle_ready: got %b want 1", ready_out); end
    @(posedge clk); #1;
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL bp_accept_ready: got %b want 0", ready_out); end
    valid_in = 1'b0;
    w = 0;
    while (!valid_out && w < 100) begin @(posedge clk); #1; w++; end
    total++; if (y !== 32'h3EAAAAAB) begin bad++; $display("FAIL bp_next_y: got %h want 3EAAAAAB", y); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int          lat, w;
    logic        seen;
    @(negedge clk);
    x1 = 32'h40C00000; x2 = 32'h40000000; valid_in = 1'b1; ready_in = 1'b1;
    w = 0;
    while (!ready_out && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (11) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    total++; if (y !== 32'd0) begin bad++; $display("FAIL midrst_y: got %h want 00000000", y); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", valid_out); end
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", ready_out); end
    @(negedge clk); rstn = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (valid_out) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_ghost: got %b want 0", seen); end
    do_op(32'h40C00000, 32'h40000000, res, lat);
    total++; if (res !== 32'h40400000) begin bad++; $display("FAIL midrst_fresh_y: got %h want 40400000", res); end
    total++; if (lat !== 28) begin bad++; $display("FAIL midrst_fresh_lat: got %0d want 28", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] oa[3], ob[3], oe[3];
    int acc[3];
    int nacc, nres;
    for (int i = 0; i < 3; i++) begin
      oa[i] = rand_fp(); ob[i] = rand_fp();
      oa[i][30:23] = 8'($urandom_range(100, 150));
      ob[i][30:23] = 8'($urandom_range(100, 150));
      oe[i] = ref_div(oa[i], ob[i]);
    end
    nacc = 0; nres = 0; ready_in = 1'b1; valid_in = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (valid_out) begin
        if (nres < 3) begin
          total++;
          if (y !== oe[nres]) begin bad++; $display("FAIL b2b_y[%0d]: got %h want %h", nres, y, oe[nres]); end
        end
        nres++;
      end
      if (ready_out) begin
        if (nacc < 3) begin
          x1 = oa[nacc]; x2 = ob[nacc]; acc[nacc] = c; nacc++;
        end else valid_in = 1'b0;
      end
    end
    valid_in = 1'b0;
    total++; if (nres !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", nres); end
    total++; if (nacc !== 3 || acc[1] - acc[0] !== 29) begin bad++; $display("FAIL b2b_interval0: got %0d want 29", acc[1] - acc[0]); end
    total++; if (nacc !== 3 || acc[2] - acc[1] !== 29) begin bad++; $display("FAIL b2b_interval1: got %0d want 29", acc[2] - acc[1]); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_slow_special();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
